// File: rtl/folded_dot.sv
// folded_dot: dot product of N weight/activation pairs, LANES elements per beat.
// The captured operand vectors are shifted down one beat each cycle, so the
// multiplier lanes always read the low LANES elements. This keeps the lane
// inputs free of a beat-indexed mux. The accumulator is wide enough that it
// never wraps. Saturation to RES_WIDTH happens once, on the final beat.
module folded_dot #(
    parameter int N            = 128,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACT_WIDTH    = 4,
    parameter int LANES        = 16,
    parameter int RES_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          i_w_signed,
    input  logic                          i_a_signed,
    input  logic [N*WEIGHT_WIDTH-1:0]     i_weights_flat,
    input  logic [N*ACT_WIDTH-1:0]        i_acts_flat,
    output logic                          ready,
    output logic                          done,
    output logic signed [RES_WIDTH-1:0]   result,
    output logic                          overflow
);

    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = WEIGHT_WIDTH + ACT_WIDTH + 2;
    localparam int ACC_W = PW + $clog2(N);
    localparam int CW    = ((ACC_W > RES_WIDTH) ? ACC_W : RES_WIDTH) + 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic signed [CW-1:0] RES_MAX =
        {{(CW-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] RES_MIN =
        {{(CW-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

    generate
        if (N % LANES != 0) begin : g_bad_lanes
            $error("folded_dot: N must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;
    logic   capture, finish;

    logic [N*WEIGHT_WIDTH-1:0] w_reg;
    logic [N*ACT_WIDTH-1:0]    a_reg;
    logic                      w_sgn, a_sgn;
    logic signed [ACC_W-1:0]   acc;
    logic [BW-1:0]             beat;

    logic signed [ACC_W-1:0]     partial;
    logic signed [ACC_W-1:0]     acc_sum;
    logic signed [CW-1:0]        sum_ext;
    logic signed [RES_WIDTH-1:0] sat_val;
    logic                        sat_hit;
    logic [WEIGHT_WIDTH-1:0]     w_el;
    logic [ACT_WIDTH-1:0]        a_el;
    logic signed [WEIGHT_WIDTH:0] w_ext;
    logic signed [ACT_WIDTH:0]   a_ext;
    logic signed [PW-1:0]        prod;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode; start only counts while the block is idle or just finished.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (beat == LAST_BEAT) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sum of the LANES products at the bottom of the shifted operand vectors.
    always_comb begin
        partial = '0;
        w_el    = '0;
        a_el    = '0;
        w_ext   = '0;
        a_ext   = '0;
        prod    = '0;
        for (int l = 0; l < LANES; l++) begin
            w_el    = w_reg[l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            a_el    = a_reg[l*ACT_WIDTH +: ACT_WIDTH];
            w_ext   = $signed({w_sgn & w_el[WEIGHT_WIDTH-1], w_el});
            a_ext   = $signed({a_sgn & a_el[ACT_WIDTH-1], a_el});
            prod    = w_ext * a_ext;
            partial = partial + ACC_W'(prod);
        end
    end

    // Running total including this beat, clamped to the result range.
    always_comb begin
        acc_sum = acc + partial;
        sum_ext = CW'(acc_sum);
        sat_hit = 1'b0;
        sat_val = RES_WIDTH'(sum_ext);
        if (sum_ext > RES_MAX) begin
            sat_hit = 1'b1;
            sat_val = RES_WIDTH'(RES_MAX);
        end else if (sum_ext < RES_MIN) begin
            sat_hit = 1'b1;
            sat_val = RES_WIDTH'(RES_MIN);
        end
    end

    // Operand capture, beat accumulation and result/handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_reg    <= '0;
            a_reg    <= '0;
            w_sgn    <= 1'b0;
            a_sgn    <= 1'b0;
            acc      <= '0;
            beat     <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            if (capture) begin
                w_reg <= i_weights_flat;
                a_reg <= i_acts_flat;
                w_sgn <= i_w_signed;
                a_sgn <= i_a_signed;
                acc   <= '0;
                beat  <= '0;
                ready <= 1'b0;
            end else if (state == RUN) begin
                acc   <= acc_sum;
                beat  <= beat + 1'b1;
                w_reg <= w_reg >> (LANES * WEIGHT_WIDTH);
                a_reg <= a_reg >> (LANES * ACT_WIDTH);
                if (finish) begin
                    result   <= sat_val;
                    overflow <= sat_hit;
                    ready    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_folded_dot.sv
// Bench for folded_dot: two instances (16-bit and 12-bit results) share the
// stimulus; a reference dot product is queued per accepted request and a
// negedge monitor compares each done against it.
module tb_folded_dot;

    localparam int N     = 128;
    localparam int WW    = 4;
    localparam int AW    = 4;
    localparam int LANES = 16;
    localparam int BEATS = N / LANES;

    typedef struct {
        longint exact;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic w_signed = 1'b0;
    logic a_signed = 1'b0;
    logic [N*WW-1:0] wv = '0;
    logic [N*AW-1:0] av = '0;

    logic ready_a, done_a, ovf_a;
    logic ready_b, done_b, ovf_b;
    logic signed [15:0] result_a;
    logic signed [11:0] result_b;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;
    bit   prev_done = 1'b0;

    folded_dot u_dut16 (
        .clk(clk), .rst(rst), .start(start),
        .i_w_signed(w_signed), .i_a_signed(a_signed),
        .i_weights_flat(wv), .i_acts_flat(av),
        .ready(ready_a), .done(done_a), .result(result_a), .overflow(ovf_a)
    );

    folded_dot #(.RES_WIDTH(12)) u_dut12 (
        .clk(clk), .rst(rst), .start(start),
        .i_w_signed(w_signed), .i_a_signed(a_signed),
        .i_weights_flat(wv), .i_acts_flat(av),
        .ready(ready_b), .done(done_b), .result(result_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    function automatic longint dot_ref(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a,
                                       input bit ws, input bit asg);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            longint wi = longint'(w[i*WW +: WW]);
            longint ai = longint'(a[i*AW +: AW]);
            if (ws && wi >= 8) wi -= 16;
            if (asg && ai >= 8) ai -= 16;
            s += wi * ai;
        end
        return s;
    endfunction

    function automatic longint sat(input longint v, input int rw);
        longint mx = (longint'(1) <<< (rw - 1)) - 1;
        longint mn = -(longint'(1) <<< (rw - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic logic [N*WW-1:0] fill(input logic [3:0] v);
        logic [N*WW-1:0] r;
        for (int i = 0; i < N; i++) r[i*WW +: WW] = v;
        return r;
    endfunction

    function automatic logic [N*WW-1:0] rand_vec();
        logic [N*WW-1:0] r;
        for (int i = 0; i < N; i++) r[i*WW +: WW] = 4'($urandom_range(0, 15));
        return r;
    endfunction

    // Monitor: every done is matched to the oldest queued request.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (done_a) begin
                check("done_one_cycle", longint'(prev_done), 0);
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", longint'(cyc - e.cyc), BEATS);
                    check("result16", longint'(result_a), sat(e.exact, 16));
                    check("overflow16", longint'(ovf_a), longint'(sat(e.exact, 16) != e.exact));
                    check("done12", longint'(done_b), 1);
                    check("result12", longint'(result_b), sat(e.exact, 12));
                    check("overflow12", longint'(ovf_b), longint'(sat(e.exact, 12) != e.exact));
                end
                check("ready_at_done", longint'(ready_a), 1);
            end else begin
                check("ready", longint'(ready_a), longint'(q.size() == 0));
            end
            prev_done = done_a;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic push_exp(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a,
                            input bit ws, input bit asg);
        exp_t x;
        x.exact = dot_ref(w, a, ws, asg);
        x.cyc   = cyc;
        q.push_back(x);
    endtask

    task automatic issue(input logic [N*WW-1:0] w, input logic [N*AW-1:0] a,
                         input bit ws, input bit asg);
        int n = 0;
        @(negedge clk);
        while (!ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_a) begin
            check("issue_ready_timeout", 0, 1);
            return;
        end
        wv = w; av = a; w_signed = ws; a_signed = asg; start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(w, a, ws, asg);
        start = 1'b0;
        wv = rand_vec();
        av = rand_vec();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || done_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("idle_timeout", longint'(q.size()), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*WW-1:0] w1, w2;
        logic [N*AW-1:0] a1, a2;
        int n;

        repeat (3) @(negedge clk);
        check("reset_ready", longint'(ready_a), 1);
        check("reset_done", longint'(done_a), 0);
        check("reset_result", longint'(result_a), 0);
        check("reset_overflow", longint'(ovf_a), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        issue(fill(4'h1), fill(4'h1), 0, 0);          // 128
        wait_idle();
        issue(fill(4'hF), fill(4'h7), 1, 1);          // -896
        wait_idle();
        issue(fill(4'hF), fill(4'h8), 0, 1);          // -15360
        wait_idle();
        issue(fill(4'hF), fill(4'hF), 0, 0);          // 28800 -> 2047 on 12 bits
        wait_idle();
        issue(fill(4'h8), fill(4'hF), 1, 0);          // -15360 -> -2048 on 12 bits
        wait_idle();

        w1 = '0; a1 = '0;
        w1[127*WW +: WW] = 4'd3; a1[127*AW +: AW] = 4'd5;
        issue(w1, a1, 0, 0);                          // 15
        wait_idle();
        w1 = '0; a1 = '0;
        w1[0 +: WW] = 4'd2; a1[0 +: AW] = 4'd7;
        issue(w1, a1, 0, 0);                          // 14
        wait_idle();

        // start pulses while busy must be ignored
        issue(fill(4'h3), fill(4'h2), 0, 0);          // 768
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wv = fill(4'hF); av = fill(4'hF); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();

        // back-to-back: new request presented during the done cycle
        w1 = rand_vec(); a1 = rand_vec();
        w2 = rand_vec(); a2 = rand_vec();
        issue(w1, a1, 1, 0);
        n = 0;
        while (!done_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done_seen", longint'(done_a), 1);
        wv = w2; av = a2; w_signed = 0; a_signed = 1; start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(w2, a2, 0, 1);
        start = 1'b0;
        wait_idle();

        // reset in the middle of an operation discards it
        issue(fill(4'h1), fill(4'h1), 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        check("midrst_ready", longint'(ready_a), 1);
        check("midrst_done", longint'(done_a), 0);
        check("midrst_result", longint'(result_a), 0);
        check("midrst_overflow", longint'(ovf_a), 0);
        check("midrst_result12", longint'(result_b), 0);
        rst = 1'b0;
        issue(fill(4'h2), fill(4'h3), 0, 0);          // 768
        wait_idle();

        // randomized requests
        for (int k = 0; k < 20; k++) begin
            issue(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (($urandom_range(0, 2)) == 0) wait_idle();
        end
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
